// File: rtl/usb_uart_line_reader.sv
`default_nettype none
// ============================================================================
//  Module   : usb_uart_line_reader
//  Purpose  : Pulls bytes from the usb_uart read port and assembles them into
//             an LF-terminated line buffer. A complete line is held for a
//             consumer, which reads it through a registered random-access port
//             and releases it with line_ack. No bytes are fetched while a line
//             is held, so USB flow control pushes back on the host.
//  Ports    : clk_48mhz  - 48 MHz USB-domain clock
//             reset      - synchronous, active-high
//             uart_re    - read request to usb_uart (registered)
//             uart_do    - read data from usb_uart
//             uart_wait  - usb_uart busy / no data
//             line_valid - a complete line is held
//             line_len   - payload byte count of the held line
//             line_ovf   - held line exceeded MAX_LEN, excess bytes dropped
//             line_addr  - consumer byte index
//             line_data  - byte at line_addr, one cycle of read latency
//             line_ack   - consumer releases the held line
//  Options  : USB_UART_LINE_READER_BACKSPACE_EN - 0x08/0x7F erase the last
//             byte instead of being stored.
//  Revision : 1.0 - initial release
// ============================================================================
module usb_uart_line_reader #(
  parameter int MAX_LEN = 32,
  parameter int AW      = $clog2(MAX_LEN),
  parameter int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic          clk_48mhz,
  input  logic          reset,
  output logic          uart_re,
  input  logic [7:0]    uart_do,
  input  logic          uart_wait,
  output logic          line_valid,
  output logic [LW-1:0] line_len,
  output logic          line_ovf,
  input  logic [AW-1:0] line_addr,
  output logic [7:0]    line_data,
  input  logic          line_ack
);

  localparam logic [7:0]    C_LF  = 8'h0A;
  localparam logic [7:0]    C_CR  = 8'h0D;
  localparam logic [7:0]    C_BS  = 8'h08;
  localparam logic [7:0]    C_DEL = 8'h7F;
  localparam logic [LW-1:0] C_MAX = LW'(MAX_LEN);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_PROC  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_uart_re;
  logic [7:0]    r_byte;
  logic [LW-1:0] r_len;
  logic          r_ovf;
  logic          r_line_valid;
  logic [7:0]    r_mem [MAX_LEN];
  logic [7:0]    r_ram_q;
  logic          r_in_range;

  logic          w_xfer;
  logic          w_is_bs;
  logic          w_store;
  logic [LW-1:0] w_len_nxt;
  logic          w_ovf_nxt;

  assign w_xfer = (r_state == S_FETCH) && r_uart_re && !uart_wait;

`ifdef USB_UART_LINE_READER_BACKSPACE_EN
  assign w_is_bs = (r_byte == C_BS) || (r_byte == C_DEL);
`else
  assign w_is_bs = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_ovf_nxt   = r_ovf;
    w_store     = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (w_xfer) begin
          w_state_nxt = S_PROC;
        end
      end
      S_PROC: begin
        w_state_nxt = S_FETCH;
        if (r_byte == C_LF) begin
          w_state_nxt = S_HOLD;
        end else if (r_byte == C_CR) begin
          w_state_nxt = S_FETCH;
        end else if (w_is_bs) begin
          if (r_len != '0) begin
            w_len_nxt = r_len - LW'(1);
          end
        end else if (r_len < C_MAX) begin
          w_store   = 1'b1;
          w_len_nxt = r_len + LW'(1);
        end else begin
          // Saturated: the byte is dropped and the line is flagged.
          w_ovf_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (line_ack) begin
          w_state_nxt = S_FETCH;
          w_len_nxt   = '0;
          w_ovf_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_uart_re    <= 1'b0;
      r_byte       <= 8'h00;
      r_len        <= '0;
      r_ovf        <= 1'b0;
      r_line_valid <= 1'b0;
      r_in_range   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      // Request follows the current state one cycle late and drops on the
      // transfer edge, so there is always an idle cycle between requests.
      r_uart_re    <= (r_state == S_FETCH) && !w_xfer;
      if (w_xfer) begin
        r_byte <= uart_do;
      end
      r_len        <= w_len_nxt;
      r_ovf        <= w_ovf_nxt;
      r_line_valid <= (w_state_nxt == S_HOLD);
      r_in_range   <= (LW'(line_addr) < r_len);
    end
  end

  // Plain write / registered read with no reset so the array maps to block RAM;
  // the range mask is applied after the RAM output register.
  always_ff @(posedge clk_48mhz) begin
    if (w_store && !reset) begin
      r_mem[r_len[AW-1:0]] <= r_byte;
    end
    r_ram_q <= r_mem[line_addr];
  end

  assign uart_re    = r_uart_re;
  assign line_valid = r_line_valid;
  assign line_len   = r_len;
  assign line_ovf   = r_ovf;
  assign line_data  = r_in_range ? r_ram_q : 8'h00;

endmodule
`default_nettype wire
